dm_arbiter: RTL

Sequences and shares the single-port data memory (DM) between two requesters. Port A is the pipeline MEM stage and has priority; port B is a secondary master (debug/DMA loader). The block is a multi-cycle access controller: it latches one command, holds it on the DM for MEM_LAT cycles, returns read data with a one-cycle done pulse, and stalls the pipeline while A waits. It sits between the MEM stage and DM, replacing the direct MEM-to-DM connection.

---
 rtl/dm_arbiter_pkg.sv | 37 +++
 rtl/dm_arb_pick.sv | 47 ++++
 rtl/dm_arbiter.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/dm_arbiter_pkg.sv
// dm_arbiter shared types: access sizes, FSM states, owner, command.
// Imported by the arbiter top and its pick sub-block.
package dm_arbiter_pkg;

  typedef enum logic [2:0] {
    SZ_NONE = 3'd0,
    SZ_BYTE = 3'd1,
    SZ_HALF = 3'd2,
    SZ_WORD = 3'd3
  } dm_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } dm_state_e;

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } dm_owner_e;

  typedef struct packed {
    logic        we;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dm_cmd_t;

  function automatic logic req_valid(
    input logic       req,
    input logic [2:0] size
  );
    return req && (size != SZ_NONE);
  endfunction

endpackage

// File: rtl/dm_arb_pick.sv
// A/B selection for the DM arbiter with B anti-starvation counter.
// A wins by default; B is forced after STARVE_MAX A grants.
module dm_arb_pick #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic idle_i,
  input  logic a_vld_i,
  input  logic b_vld_i,
  output logic pick_a_o,
  output logic pick_b_o
);
  import dm_arbiter_pkg::*;

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  logic [3:0] starve_q;
  logic [3:0] starve_d;
  logic       starved;

  assign starved  = (starve_q == SMAX);
  assign pick_b_o = idle_i & b_vld_i & (~a_vld_i | starved);
  assign pick_a_o = idle_i & a_vld_i & ~pick_b_o;

  // Count A wins over a waiting B; clear once B is served or gone.
  always_comb begin
    starve_d = starve_q;
    if (idle_i) begin
      if (!b_vld_i || pick_b_o) begin
        starve_d = '0;
      end else if (pick_a_o && !starved) begin
        starve_d = starve_q + 4'd1;
      end
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// Two-port multi-cycle access controller for the single-port data memory.
// Port A (MEM stage) has priority and is stalled while it waits.
module dm_arbiter #(
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [2:0]  a_size,
  input  logic [31:0] a_addr,
  input  logic [31:0] a_wdata,
  output logic [31:0] a_rdata,
  output logic        a_done,
  output logic        stall,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [2:0]  b_size,
  input  logic [31:0] b_addr,
  input  logic [31:0] b_wdata,
  output logic [31:0] b_rdata,
  output logic        b_done,
  output logic        dm_en,
  output logic        dm_we,
  output logic [2:0]  dm_size,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata
);
  import dm_arbiter_pkg::*;

  localparam logic [2:0] LAT_INIT = 3'(MEM_LAT - 1);

  dm_state_e   state_q;
  dm_state_e   state_d;
  dm_owner_e   owner_q;
  dm_owner_e   owner_d;
  dm_cmd_t     cmd_q;
  dm_cmd_t     cmd_d;
  logic [2:0]  lat_q;
  logic [2:0]  lat_d;
  logic [31:0] a_rdata_q;
  logic [31:0] a_rdata_d;
  logic [31:0] b_rdata_q;
  logic [31:0] b_rdata_d;

  logic a_vld;
  logic b_vld;
  logic pick_a;
  logic pick_b;
  logic idle;
  logic busy;
  logic done;

  assign a_vld = req_valid(a_req, a_size);
  assign b_vld = req_valid(b_req, b_size);
  assign idle  = (state_q == IDLE);
  assign busy  = (state_q == BUSY);
  assign done  = (state_q == DONE);

  dm_arb_pick #(
    .STARVE_MAX(STARVE_MAX)
  ) u_pick (
    .clk      (clk),
    .reset    (reset),
    .idle_i   (idle),
    .a_vld_i  (a_vld),
    .b_vld_i  (b_vld),
    .pick_a_o (pick_a),
    .pick_b_o (pick_b)
  );

  // Latch the winner in IDLE, count latency in BUSY, pulse in DONE.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    cmd_d     = cmd_q;
    lat_d     = lat_q;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (pick_b) begin
          owner_d       = OWN_B;
          cmd_d.we      = b_we;
          cmd_d.size    = b_size;
          cmd_d.addr    = b_addr;
          cmd_d.wdata   = b_wdata;
        end else if (pick_a) begin
          owner_d       = OWN_A;
          cmd_d.we      = a_we;
          cmd_d.size    = a_size;
          cmd_d.addr    = a_addr;
          cmd_d.wdata   = a_wdata;
        end
        if (pick_a || pick_b) begin
          state_d = BUSY;
          lat_d   = LAT_INIT;
        end
      end
      BUSY: begin
        if (lat_q == '0) begin
          state_d = DONE;
          if (!cmd_q.we) begin
            if (owner_q == OWN_B) begin
              b_rdata_d = dm_rdata;
            end else begin
              a_rdata_d = dm_rdata;
            end
          end
        end else begin
          lat_d = lat_q - 3'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, command and response registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      owner_q   <= OWN_A;
      cmd_q     <= '0;
      lat_q     <= '0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      cmd_q     <= cmd_d;
      lat_q     <= lat_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  assign dm_en    = busy;
  assign dm_we    = busy & cmd_q.we;
  assign dm_size  = busy ? cmd_q.size  : '0;
  assign dm_addr  = busy ? cmd_q.addr  : '0;
  assign dm_wdata = busy ? cmd_q.wdata : '0;

  assign a_done  = done & (owner_q == OWN_A);
  assign b_done  = done & (owner_q == OWN_B);
  assign stall   = a_vld & ~a_done;
  assign a_rdata = a_rdata_q;
  assign b_rdata = b_rdata_q;

endmodule
